piso_arb: RTL and testbench

PISO_ARB -- requirements
Module: piso_arb

---
 rtl/piso_arb.sv | 138 +++++++++++++
 tb/tb_piso_arb.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_arb.sv
// piso_arb: round-robin arbiter that serialises wide words from NUM_PORT requesters into narrow beats.
// Define PISO_ARB_CACHE_EN to add a one-word buffer (plus LAST flag) between the granted port and the serialiser.
module piso_arb #(
    parameter int NUM_PORT       = 4,
    parameter int DATA_IN_WIDTH  = 64,
    parameter int DATA_OUT_WIDTH = 16
) (
    input  logic                              CLK,
    input  logic                              RST_N,
    input  logic                              RESET,
    input  logic [NUM_PORT-1:0]               IN_VLD,
    input  logic [NUM_PORT-1:0]               IN_LAST,
    input  logic [NUM_PORT*DATA_IN_WIDTH-1:0] IN_DAT,
    output logic [NUM_PORT-1:0]               IN_RDY,
    output logic [DATA_OUT_WIDTH-1:0]         OUT_DAT,
    output logic                              OUT_VLD,
    output logic                              OUT_LAST,
    output logic [$clog2(NUM_PORT)-1:0]       OUT_PORT,
    input  logic                              OUT_RDY
);
    localparam int NUM_SHIFTS = DATA_IN_WIDTH / DATA_OUT_WIDTH;
    localparam int CW         = $clog2(NUM_SHIFTS);
    localparam int PW         = $clog2(NUM_PORT);
    localparam logic [CW-1:0] CNT_MAX  = CW'(NUM_SHIFTS - 1);
    localparam logic [PW-1:0] PORT_MAX = PW'(NUM_PORT - 1);

    typedef enum logic {IDLE, SERIAL} state_t;

    state_t                     state;
    logic [CW-1:0]              cnt;
    logic [PW-1:0]              ptr;
    logic [PW-1:0]              grant;
    logic [PW-1:0]              pick;
    logic [PW-1:0]              idx;
    logic                       serial;
    logic                       last_slice;
    logic                       hs;
    logic                       fin;
    logic                       done;
    logic                       src_vld;
    logic                       src_last;
    logic [DATA_IN_WIDTH-1:0]   src_word;
    logic [NUM_PORT-1:0]        grant_oh;

    // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
    // Scanning downwards lets the closest requester at or after ptr win.
    always_comb begin
        pick = ptr;
        idx  = ptr;
        for (int i = NUM_PORT - 1; i >= 0; i--) begin
            idx = PW'((int'(ptr) + i) % NUM_PORT);
            if (IN_VLD[idx]) pick = idx;
        end
    end

    assign grant_oh   = NUM_PORT'(1) << grant;
    assign serial     = (state == SERIAL);
    assign last_slice = (cnt == CNT_MAX);

`ifdef PISO_ARB_CACHE_EN
    logic                     buf_vld;
    logic                     buf_last;
    logic                     cap;
    logic [DATA_IN_WIDTH-1:0] buf_word;

    // Refill is allowed on the cycle the final beat leaves, unless that word closed the packet.
    assign cap      = serial && !RESET && IN_VLD[grant] && (!buf_vld || (fin && !buf_last));
    assign IN_RDY   = cap ? grant_oh : '0;
    assign src_vld  = buf_vld;
    assign src_last = buf_last;
    assign src_word = buf_word;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            buf_vld  <= 1'b0;
            buf_last <= 1'b0;
        end else if (RESET) begin
            buf_vld  <= 1'b0;
            buf_last <= 1'b0;
        end else if (cap) begin
            buf_vld  <= 1'b1;
            buf_last <= IN_LAST[grant];
        end else if (fin) begin
            buf_vld  <= 1'b0;
        end
    end

    // NOTE: the data word is qualified by buf_vld, so it needs no reset and stays a plain register.
    always_ff @(posedge CLK) begin
        if (cap) buf_word <= IN_DAT[int'(grant)*DATA_IN_WIDTH +: DATA_IN_WIDTH];
    end
`else
    assign IN_RDY   = (serial && !RESET && last_slice && OUT_RDY) ? grant_oh : '0;
    assign src_vld  = IN_VLD[grant];
    assign src_last = IN_LAST[grant];
    assign src_word = IN_DAT[int'(grant)*DATA_IN_WIDTH +: DATA_IN_WIDTH];
`endif

    assign OUT_VLD  = serial && src_vld;
    assign OUT_DAT  = OUT_VLD ? src_word[int'(cnt)*DATA_OUT_WIDTH +: DATA_OUT_WIDTH] : '0;
    assign OUT_LAST = OUT_VLD && src_last && last_slice;
    assign OUT_PORT = grant;
    assign hs       = OUT_VLD && OUT_RDY;
    assign fin      = hs && last_slice;
    assign done     = fin && src_last;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= '0;
            grant <= '0;
        end else if (RESET) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= '0;
            grant <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|IN_VLD) begin
                        grant <= pick;
                        cnt   <= '0;
                        state <= SERIAL;
                    end
                end
                SERIAL: begin
                    if (hs) cnt <= last_slice ? '0 : cnt + CW'(1);
                    if (done) begin
                        state <= IDLE;
                        ptr   <= (grant == PORT_MAX) ? '0 : grant + PW'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_piso_arb.sv
// Self-checking bench for piso_arb: per-port source queues, per-port expected-beat scoreboard, packet-order log.
// Build with PISO_ARB_CACHE_EN defined to exercise the buffered variant.
module tb_piso_arb;
    localparam int NP  = 4;
    localparam int DIW = 64;
    localparam int DOW = 16;
    localparam int NS  = DIW / DOW;

    typedef struct { logic [DIW-1:0] dat; logic last; } word_t;
    typedef struct { logic [DOW-1:0] dat; logic last; logic fin; } beat_t;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              RESET;
    logic [NP-1:0]     IN_VLD;
    logic [NP-1:0]     IN_LAST;
    logic [NP*DIW-1:0] IN_DAT;
    logic [NP-1:0]     IN_RDY;
    logic [DOW-1:0]    OUT_DAT;
    logic              OUT_VLD;
    logic              OUT_LAST;
    logic [1:0]        OUT_PORT;
    logic              OUT_RDY;

    piso_arb #(.NUM_PORT(NP), .DATA_IN_WIDTH(DIW), .DATA_OUT_WIDTH(DOW)) dut (
        .CLK(CLK), .RST_N(RST_N), .RESET(RESET),
        .IN_VLD(IN_VLD), .IN_LAST(IN_LAST), .IN_DAT(IN_DAT), .IN_RDY(IN_RDY),
        .OUT_DAT(OUT_DAT), .OUT_VLD(OUT_VLD), .OUT_LAST(OUT_LAST), .OUT_PORT(OUT_PORT),
        .OUT_RDY(OUT_RDY)
    );

    always #5 CLK = ~CLK;

    word_t src_q[NP][$];
    beat_t exp_q[NP][$];
    int    pkt_log[$];
    int    beat_cyc[NP][$];
    int    rdy_cyc[NP][$];

    int       n_vec = 0;
    int       n_err = 0;
    int       cyc = 0;
    int       rdy_mode = 0;
    bit       drop_en = 1'b0;
    bit       sync_rst = 1'b0;
    bit       prev_stall = 1'b0;
    logic [DOW-1:0] prev_dat = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DIW-1:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic expect_word(input int p, input logic [DIW-1:0] dat, input logic last);
        for (int s = 0; s < NS; s++)
            exp_q[p].push_back('{dat: dat[s*DOW +: DOW], last: last && (s == NS-1), fin: (s == NS-1)});
    endtask

    task automatic push_word(input int p, input logic [DIW-1:0] dat, input logic last);
        src_q[p].push_back('{dat: dat, last: last});
        expect_word(p, dat, last);
    endtask

    function automatic int next_log();
        if (pkt_log.size() == 0) return -1;
        return pkt_log.pop_front();
    endfunction

    function automatic bit pending();
        for (int p = 0; p < NP; p++)
            if (src_q[p].size() != 0 || exp_q[p].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: drive at the falling edge, sample 1 time unit before the rising edge.
    task automatic step();
        int             p;
        beat_t          b;
        logic [NP-1:0]  exp_rdy;
        @(negedge CLK);
        cyc++;
        for (int q = 0; q < NP; q++) begin
            if (src_q[q].size() != 0 && (!drop_en || $urandom_range(0, 3) != 0)) begin
                IN_VLD[q]              = 1'b1;
                IN_LAST[q]             = src_q[q][0].last;
                IN_DAT[q*DIW +: DIW]   = src_q[q][0].dat;
            end else begin
                IN_VLD[q]              = 1'b0;
                IN_LAST[q]             = 1'b0;
                IN_DAT[q*DIW +: DIW]   = '0;
            end
        end
        case (rdy_mode)
            0:       OUT_RDY = 1'b1;
            1:       OUT_RDY = cyc[0];
            2:       OUT_RDY = 1'($urandom_range(0, 1));
            default: OUT_RDY = 1'b0;
        endcase
        RESET = sync_rst;
        #4;
        if (OUT_VLD && OUT_RDY) begin
            p = int'(OUT_PORT);
            check("beat_expected", exp_q[p].size() != 0, 1);
            if (exp_q[p].size() != 0) begin
                b = exp_q[p].pop_front();
                check("beat_dat", OUT_DAT, b.dat);
                check("beat_last", OUT_LAST, b.last);
`ifndef PISO_ARB_CACHE_EN
                exp_rdy = b.fin ? NP'(1) << p : '0;
                check("in_rdy", IN_RDY, exp_rdy);
`endif
                beat_cyc[p].push_back(cyc);
                if (OUT_LAST) pkt_log.push_back(p);
            end
        end else if (!OUT_VLD) begin
            check("idle_dat", OUT_DAT, 0);
            check("idle_last", OUT_LAST, 0);
        end
        if (prev_stall && OUT_VLD) check("hold_dat", OUT_DAT, prev_dat);
        prev_stall = OUT_VLD && !OUT_RDY;
        prev_dat   = OUT_DAT;
        check("rdy_onehot", $onehot0(IN_RDY), 1);
        check("rdy_granted_only", IN_RDY & ~(NP'(1) << OUT_PORT), 0);
        for (int q = 0; q < NP; q++) begin
            if (IN_VLD[q] && IN_RDY[q]) begin
                void'(src_q[q].pop_front());
                rdy_cyc[q].push_back(cyc);
            end
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (pending() && n < budget) begin
            step();
            n++;
        end
        check("drain_left", pending(), 0);
        for (int p = 0; p < NP; p++) begin
            src_q[p].delete();
            exp_q[p].delete();
        end
    endtask

    initial begin
        int n;
        int npk;
        int p;
        logic last;
        logic [DIW-1:0] w;

        RST_N   = 1'b0;
        RESET   = 1'b0;
        IN_VLD  = '1;
        IN_LAST = '1;
        IN_DAT  = {NP{64'hA5A5_5A5A_F00D_CAFE}};
        OUT_RDY = 1'b1;
        #12;
        check("por_vld", OUT_VLD, 0);
        check("por_last", OUT_LAST, 0);
        check("por_dat", OUT_DAT, 0);
        check("por_port", OUT_PORT, 0);
        check("por_rdy", IN_RDY, 0);
        @(negedge CLK);
        IN_VLD  = '0;
        IN_LAST = '0;
        RST_N   = 1'b1;

        // All four ports keep single-word packets queued: strict 0,1,2,3 rotation.
        for (int k = 0; k < 2; k++)
            for (int q = 0; q < NP; q++) push_word(q, rand64(), 1'b1);
        drain(400);
        for (int i = 0; i < 2 * NP; i++) check("rr_order", next_log(), i % NP);

        // Single word from port 2: first beat one cycle after the request is sampled.
        pkt_log.delete();
        rdy_cyc[2].delete();
        push_word(2, 64'h4444_3333_2222_1111, 1'b1);
        step();
        check("req_cycle_vld", OUT_VLD, 0);
        check("req_cycle_rdy", IN_RDY, 0);
        step();
`ifdef PISO_ARB_CACHE_EN
        check("capture_rdy", IN_RDY, 4'b0100);
        check("capture_vld", OUT_VLD, 0);
        step();
`endif
        check("first_vld", OUT_VLD, 1);
        check("first_dat", OUT_DAT, 16'h1111);
        check("first_port", OUT_PORT, 2);
        drain(50);
        check("p2_order", next_log(), 2);
        check("p2_rdy_pulses", rdy_cyc[2].size(), 1);

        // Port 1 three-word packet locks the grant while port 0 waits.
        beat_cyc[1].delete();
        for (int k = 0; k < 3; k++) push_word(1, rand64(), k == 2);
        step();
        push_word(0, rand64(), 1'b1);
        drain(100);
        check("lock_first", next_log(), 1);
        check("lock_second", next_log(), 0);
        check("lock_beats", beat_cyc[1].size(), 3 * NS);
        check("lock_contig", beat_cyc[1][3*NS-1] - beat_cyc[1][0], 3 * NS - 1);

        // Downstream back-pressure alternating every cycle.
        rdy_mode = 1;
        push_word(3, rand64(), 1'b0);
        push_word(3, rand64(), 1'b1);
        drain(100);
        rdy_mode = 0;
        check("bp_order", next_log(), 3);

        // Port 2 word first so ptr sits at 3, then a second word is cut by RESET after two beats.
        w = 64'h4444_3333_2222_1111;
        push_word(2, rand64(), 1'b1);
        drain(50);
        check("pre_rst_order", next_log(), 2);
        push_word(2, w, 1'b1);
        n = 0;
        while (exp_q[2].size() > 2 && n < 20) begin
            step();
            n++;
        end
        check("rst_setup", exp_q[2].size(), 2);
        rdy_mode = 3;
        sync_rst = 1'b1;
        step();
        sync_rst = 1'b0;
        rdy_mode = 0;
        exp_q[2].delete();
        expect_word(2, w, 1'b1);
        push_word(0, rand64(), 1'b1);
        push_word(3, rand64(), 1'b1);
        step();
        check("rst_vld", OUT_VLD, 0);
        check("rst_rdy", IN_RDY, 0);
        check("rst_port", OUT_PORT, 0);
        drain(100);
        check("rst_order0", next_log(), 0);
        check("rst_order1", next_log(), 2);
        check("rst_order2", next_log(), 3);

`ifdef PISO_ARB_CACHE_EN
        // Buffered build: two back-to-back words from port 3 with no bubble between them.
        beat_cyc[3].delete();
        rdy_cyc[3].delete();
        push_word(3, rand64(), 1'b0);
        push_word(3, rand64(), 1'b1);
        drain(100);
        check("cache_rdy_pulses", rdy_cyc[3].size(), 2);
        check("cache_rdy_gap", rdy_cyc[3][1] - rdy_cyc[3][0], NS);
        check("cache_beats", beat_cyc[3].size(), 2 * NS);
        check("cache_contig", beat_cyc[3][2*NS-1] - beat_cyc[3][0], 2 * NS - 1);
        check("cache_order", next_log(), 3);
`endif

        // Random traffic with valid drops and random back-pressure; every port ends on a last word.
        pkt_log.delete();
        drop_en  = 1'b1;
        rdy_mode = 2;
        npk = 0;
        for (int k = 0; k < 30; k++) begin
            p    = $urandom_range(0, NP - 1);
            last = ($urandom_range(0, 2) == 0);
            push_word(p, rand64(), last);
            if (last) npk++;
        end
        for (int q = 0; q < NP; q++) begin
            push_word(q, rand64(), 1'b1);
            npk++;
        end
        drain(5000);
        check("rand_pkts", pkt_log.size(), npk);
        drop_en  = 1'b0;
        rdy_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
